dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 14 +
 rtl/y86_pkg.sv | 27 ++
 rtl/dmem_if.sv | 24 ++
 rtl/dmem_array.sv | 25 ++
 rtl/dmem_responder.sv | 85 ++++++++
 tb/tb_dmem_responder.sv | 164 ++++++++++++++++
 6 files changed

// File: rtl/dmem_responder_pkg.sv
// Local types for the data-memory responder: FSM states, latency counter, range check.
package dmem_responder_pkg;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} dmem_state_e;

  localparam int unsigned CntW = 4;
  typedef logic [CntW-1:0] cnt_t;

  // Full 64-bit compare so huge addresses never alias back into the store.
  function automatic logic addr_in_range(input logic [63:0] addr, input int unsigned depth);
    return addr < (64'(depth) << 3);
  endfunction

endpackage

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: status codes and instruction codes used by every pipeline stage.
package y86_pkg;

  typedef logic [2:0] stat_t;

  localparam stat_t StatNone = 3'b000;
  localparam stat_t StatAok  = 3'b001;
  localparam stat_t StatHlt  = 3'b010;
  localparam stat_t StatAdr  = 3'b011;
  localparam stat_t StatIns  = 3'b100;

  typedef logic [3:0] icode_t;

  localparam icode_t IHalt   = 4'h0;
  localparam icode_t INop    = 4'h1;
  localparam icode_t IRrmovq = 4'h2;
  localparam icode_t IIrmovq = 4'h3;
  localparam icode_t IRmmovq = 4'h4;
  localparam icode_t IMrmovq = 4'h5;
  localparam icode_t IOpq    = 4'h6;
  localparam icode_t IJxx    = 4'h7;
  localparam icode_t ICall   = 4'h8;
  localparam icode_t IRet    = 4'h9;
  localparam icode_t IPushq  = 4'hA;
  localparam icode_t IPopq   = 4'hB;

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between a memory initiator and the data-memory responder.
interface dmem_if;
  import y86_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  stat_t       resp_stat;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_stat
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_stat
  );
endinterface

// File: rtl/dmem_array.sv
// 64-bit word store: one synchronous write port, one registered read port.
module dmem_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [63:0]   i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [63:0]   o_rdata
);

  logic [63:0] r_mem [DEPTH] = '{default: '0};
  logic [63:0] r_rdata = '0;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Y86 data-memory responder: single outstanding request, fixed LAT-cycle response latency.
module dmem_responder
  import y86_pkg::*;
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned LAT   = 2
) (
  input logic i_clk,
  input logic i_rst_n,
  dmem_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam cnt_t LatInit = cnt_t'(LAT - 1);

  dmem_state_e r_state, w_state_nxt;
  cnt_t        r_cnt, w_cnt_nxt;
  logic        r_we, r_err;
  logic        w_accept, w_in_range;
  logic [63:0] w_rdata;

  assign bus.req_ready = (r_state == StIdle) & i_rst_n;
  assign w_accept      = bus.req_valid & bus.req_ready;
  assign w_in_range    = addr_in_range(bus.req_addr, DEPTH);

  // Store access happens on the accept edge; the read word is held in the array's register.
  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .i_clk   (i_clk),
    .i_we    (w_accept & bus.req_we & w_in_range),
    .i_waddr (bus.req_addr[AW+2:3]),
    .i_wdata (bus.req_wdata),
    .i_re    (w_accept & ~bus.req_we & w_in_range),
    .i_raddr (bus.req_addr[AW+2:3]),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_we  <= bus.req_we;
        r_err <= ~w_in_range;
      end
    end
  end

  // Every request passes through BUSY so resp_valid rises exactly LAT edges after accept.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;
    bus.resp_stat  = StatNone;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_nxt = StBusy;
          w_cnt_nxt   = LatInit;
        end
      end
      StBusy: begin
        if (r_cnt == '0) w_state_nxt = StResp;
        else             w_cnt_nxt   = r_cnt - cnt_t'(1);
      end
      StResp: begin
        bus.resp_valid = 1'b1;
        bus.resp_stat  = r_err ? StatAdr : StatAok;
        bus.resp_rdata = (r_we || r_err) ? 64'd0 : w_rdata;
        if (bus.resp_ready) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Drives a LAT=2 and a LAT=1 responder in lockstep against an array model of the store.
module tb_dmem_responder;
  import y86_pkg::*;

  localparam int unsigned Depth = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_ready = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_errs = 0;
  logic [63:0] model [Depth];

  dmem_if bus_l2 ();
  dmem_if bus_l1 ();

  assign bus_l2.req_valid  = req_valid;
  assign bus_l2.req_we     = req_we;
  assign bus_l2.req_addr   = req_addr;
  assign bus_l2.req_wdata  = req_wdata;
  assign bus_l2.resp_ready = resp_ready;
  assign bus_l1.req_valid  = req_valid;
  assign bus_l1.req_we     = req_we;
  assign bus_l1.req_addr   = req_addr;
  assign bus_l1.req_wdata  = req_wdata;
  assign bus_l1.resp_ready = resp_ready;

  dmem_responder #(.DEPTH(Depth), .LAT(2)) u_dut_l2 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_l2));
  dmem_responder #(.DEPTH(Depth), .LAT(1)) u_dut_l1 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_l1));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_l2_valid"}, 64'(bus_l2.resp_valid), 64'd0);
    check_eq({tag, "_l2_stat"}, 64'(bus_l2.resp_stat), 64'd0);
    check_eq({tag, "_l2_rdata"}, bus_l2.resp_rdata, 64'd0);
    check_eq({tag, "_l1_valid"}, 64'(bus_l1.resp_valid), 64'd0);
    check_eq({tag, "_l1_stat"}, 64'(bus_l1.resp_stat), 64'd0);
    check_eq({tag, "_l1_rdata"}, bus_l1.resp_rdata, 64'd0);
  endtask

  // Full transaction starting at a negedge with both responders idle.
  task automatic do_txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                        input int hold);
    logic        ok;
    logic [63:0] exp_rdata;
    logic [63:0] exp_stat;
    ok        = addr < 64'(Depth) * 64'd8;
    exp_stat  = ok ? 64'd1 : 64'd3;
    exp_rdata = (!we && ok) ? model[int'(addr >> 3)] : 64'd0;
    if (we && ok) model[int'(addr >> 3)] = wdata;

    check_eq("req_ready_idle_l2", 64'(bus_l2.req_ready), 64'd1);
    check_eq("req_ready_idle_l1", 64'(bus_l1.req_ready), 64'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    resp_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(negedge clk);
    // A competing request stays asserted and must be ignored until the response completes.
    req_we     = ~we;
    req_addr   = {$urandom, $urandom};
    req_wdata  = {$urandom, $urandom};
    resp_ready = 1'($urandom_range(0, 1));
    check_eq("busy_l2_valid", 64'(bus_l2.resp_valid), 64'd0);
    check_eq("busy_l1_valid", 64'(bus_l1.resp_valid), 64'd0);
    @(negedge clk);
    resp_ready = 1'b0;
    check_eq("lat1_valid", 64'(bus_l1.resp_valid), 64'd1);
    check_eq("lat2_early_valid", 64'(bus_l2.resp_valid), 64'd0);
    check_eq("lat1_stat", 64'(bus_l1.resp_stat), exp_stat);
    check_eq("lat1_rdata", bus_l1.resp_rdata, exp_rdata);
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      check_eq("lat2_valid", 64'(bus_l2.resp_valid), 64'd1);
      check_eq("lat2_stat", 64'(bus_l2.resp_stat), exp_stat);
      check_eq("lat2_rdata", bus_l2.resp_rdata, exp_rdata);
      check_eq("hold_l1_valid", 64'(bus_l1.resp_valid), 64'd1);
      check_eq("hold_l1_rdata", bus_l1.resp_rdata, exp_rdata);
      check_eq("resp_req_ready_l2", 64'(bus_l2.req_ready), 64'd0);
      check_eq("resp_req_ready_l1", 64'(bus_l1.req_ready), 64'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check_idle("release");
  endtask

  initial begin
    logic [63:0] d0, d1, a;
    for (int i = 0; i < int'(Depth); i++) model[i] = '0;

    repeat (3) @(negedge clk);
    check_idle("reset");
    check_eq("reset_req_ready_l2", 64'(bus_l2.req_ready), 64'd0);
    check_eq("reset_req_ready_l1", 64'(bus_l1.req_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_txn(1'b0, 64'h100, 64'd0, 0);
    do_txn(1'b1, 64'h40, 64'h1234, 0);
    do_txn(1'b0, 64'h40, 64'd0, 1);
    do_txn(1'b0, 64'h45, 64'd0, 0);
    do_txn(1'b0, 64'h2000, 64'd0, 0);
    do_txn(1'b0, 64'h1FFF, 64'd0, 0);
    do_txn(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hDEAD_BEEF, 0);
    do_txn(1'b0, 64'h1FF8, 64'd0, 0);
    do_txn(1'b0, 64'h0, 64'd0, 0);
    do_txn(1'b1, 64'h08, 64'hAA, 0);

    // Reset while both responders are in BUSY: the read must vanish without a response.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 64'h08;
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 1'b0;
    check_eq("rst_busy_req_ready_l2", 64'(bus_l2.req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_idle("abandoned");
    end
    do_txn(1'b0, 64'h08, 64'd0, 0);

    d0 = {$urandom, $urandom};
    d1 = {$urandom, $urandom};
    do_txn(1'b1, 64'h0, d0, 0);
    do_txn(1'b1, 64'h1FF8, d1, 0);
    do_txn(1'b0, 64'h0, 64'd0, 0);
    do_txn(1'b0, 64'h08, 64'd0, 0);
    do_txn(1'b0, 64'h1FF0, 64'd0, 0);
    do_txn(1'b0, 64'h1FF8, 64'd0, 0);
    do_txn(1'b0, 64'h40, 64'd0, 5);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) a = 64'h2000 + ({$urandom, $urandom} >> 1);
      else a = 64'($urandom_range(0, 31)) * 64'd8 + 64'($urandom_range(0, 7));
      do_txn(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
